// File: rtl/shift_defs_pkg.sv
// Shared encodings for the serial word deserializer:
// FSM state and shift-direction constants.
package shift_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/deser_shift_core.sv
// Data shift register and bit counter for one frame.
// last flags that the current strobe carries the final data bit.
import shift_defs::*;

module deser_shift_core #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sin,
    input  logic             clr,
    output logic [WIDTH-1:0] sr,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr    <= '0;
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (dir == DIR_LSB)
                sr <= {sin, sr[WIDTH-1:1]};
            else
                sr <= {sr[WIDTH-2:0], sin};
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_deserializer.sv
// Start-bit framed serial receiver with a one-deep valid/ready
// output slot and a sticky overrun flag.
import shift_defs::*;

module serial_word_deserializer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             msb_first,
    input  logic             q_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] qp,
    output logic             q_valid,
    output logic             busy,
    output logic             ovr
);

    state_t           state;
    logic             dir_q;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] word;
    logic             last;
    logic             start;
    logic             shift_en;
    logic             done;
    logic             slot_open;

    assign start     = sin_en && (state == ST_IDLE) && sin;
    assign shift_en  = sin_en && (state == ST_SHIFT);
    assign done      = shift_en && last;
    assign slot_open = !q_valid || q_ready;

    // The slot captures the word as it will look after this edge's shift.
    assign word = (dir_q == DIR_MSB) ? {sr[WIDTH-2:0], sin}
                                     : {sin, sr[WIDTH-1:1]};

    deser_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .en   (shift_en),
        .dir  (dir_q),
        .sin  (sin),
        .clr  (start),
        .sr   (sr),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            dir_q   <= DIR_LSB;
            busy    <= 1'b0;
            qp      <= '0;
            q_valid <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SHIFT;
                        dir_q <= msb_first;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (done && slot_open) begin
                qp      <= word;
                q_valid <= 1'b1;
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end

            // A drop on the same edge beats a clear request.
            if (done && !slot_open)
                ovr <= 1'b1;
            else if (clr_ovr)
                ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench: a frame-level model predicts delivered words,
// a negedge monitor pops and compares on every handshake.
module tb_serial_word_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sin = 1'b0;
    logic         sin_en = 1'b0;
    logic         msb_first = 1'b0;
    logic         q_ready = 1'b0;
    logic         clr_ovr = 1'b0;
    logic [W-1:0] qp;
    logic         q_valid;
    logic         busy;
    logic         ovr;

    int checks = 0;
    int fails = 0;
    bit rand_mode = 1'b0;

    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    serial_word_deserializer #(.WIDTH(W), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .sin       (sin),
        .sin_en    (sin_en),
        .msb_first (msb_first),
        .q_ready   (q_ready),
        .clr_ovr   (clr_ovr),
        .qp        (qp),
        .q_valid   (q_valid),
        .busy      (busy),
        .ovr       (ovr)
    );

    task automatic check_bit(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_word(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collect bits of a frame in a queue, assemble the
    // word arithmetically, and keep a one-entry output slot.
    bit           m_inframe = 0;
    bit           m_dir = 0;
    bit           m_valid = 0;
    bit           m_ovr = 0;
    logic [W-1:0] m_qp = '0;
    bit           m_bits[$];
    bit           m_have;
    bit           m_drop;
    logic [W-1:0] m_word;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_inframe = 0;
            m_valid   = 0;
            m_ovr     = 0;
            m_qp      = '0;
            m_bits.delete();
            exp_q.delete();
        end else begin
            m_have = 0;
            m_word = '0;
            if (sin_en) begin
                if (!m_inframe) begin
                    if (sin) begin
                        m_inframe = 1;
                        m_dir = msb_first;
                        m_bits.delete();
                    end
                end else begin
                    m_bits.push_back(sin);
                    if (m_bits.size() == W) begin
                        for (int i = 0; i < W; i++) begin
                            if (m_dir) m_word[W-1-i] = m_bits[i];
                            else       m_word[i] = m_bits[i];
                        end
                        m_have = 1;
                        m_inframe = 0;
                    end
                end
            end
            m_drop = m_have && m_valid && !q_ready;
            if (m_have && (!m_valid || q_ready)) begin
                m_qp = m_word;
                m_valid = 1;
                exp_q.push_back(m_word);
            end else if (m_valid && q_ready) begin
                m_valid = 0;
            end
            if (m_drop) m_ovr = 1;
            else if (clr_ovr) m_ovr = 0;
        end
    end

    // Monitor: compare status every cycle, pop the scoreboard on transfers.
    logic [W-1:0] popped;

    always @(negedge clk) begin
        if (rst) begin
            check_bit("q_valid", q_valid, m_valid);
            check_bit("ovr", ovr, m_ovr);
            check_bit("busy", busy, m_inframe);
            if (m_valid) check_word("qp_hold", qp, m_qp);
            if (q_valid && q_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL xfer: got word %b expected none", qp);
                end else begin
                    popped = exp_q.pop_front();
                    if (qp !== popped) begin
                        fails++;
                        $display("FAIL xfer: got %b expected %b", qp, popped);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_mode) begin
            q_ready = 1'($urandom_range(0, 1));
            clr_ovr = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic strobe(logic b, int gap);
        sin = b;
        sin_en = 1'b1;
        tick();
        sin_en = 1'b0;
        sin = 1'b0;
        repeat (gap) tick();
    endtask

    // bits[W-1] goes on the line first; returns right after the last edge.
    task automatic send_frame(logic [W-1:0] bits, logic msb, int gap,
                              bit toggle, bit rdy_last);
        msb_first = msb;
        strobe(1'b1, gap);
        for (int i = 0; i < W; i++) begin
            if (toggle && i == 1) msb_first = ~msb_first;
            if (rdy_last && i == W - 1) q_ready = 1'b1;
            strobe(bits[W-1-i], (i == W - 1) ? 0 : gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        check_word("rst_qp", qp, 4'b0000);
        check_bit("rst_valid", q_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_ovr", ovr, 1'b0);
        rst = 1'b1;
        tick();

        // 1: reset in the middle of a frame
        msb_first = 1'b1;
        strobe(1'b1, 1);
        strobe(1'b1, 1);
        strobe(1'b0, 1);
        rst = 1'b0;
        tick();
        check_word("midrst_qp", qp, 4'b0000);
        check_bit("midrst_valid", q_valid, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_ovr", ovr, 1'b0);
        rst = 1'b1;
        tick();
        repeat (6) strobe(1'b0, 1);
        check_bit("idle_valid", q_valid, 1'b0);
        check_bit("idle_busy", busy, 1'b0);

        // 2: MSB first
        q_ready = 1'b1;
        send_frame(4'b1010, 1'b1, 1, 0, 0);
        check_word("msb_qp", qp, 4'b1010);
        check_bit("msb_valid", q_valid, 1'b1);
        tick();
        check_bit("msb_valid_fall", q_valid, 1'b0);

        // 3: LSB first, direction toggled mid-frame
        send_frame(4'b0011, 1'b0, 1, 1, 0);
        check_word("lsb_qp", qp, 4'b1100);
        tick();

        // 4: backpressure and overrun
        q_ready = 1'b0;
        send_frame(4'b1010, 1'b1, 1, 0, 0);
        tick();
        send_frame(4'b0110, 1'b1, 1, 0, 0);
        tick();
        check_word("ovr_qp", qp, 4'b1010);
        check_bit("ovr_set", ovr, 1'b1);
        check_bit("ovr_valid", q_valid, 1'b1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check_bit("ovr_clr", ovr, 1'b0);
        q_ready = 1'b1;
        tick();
        check_bit("drain_valid", q_valid, 1'b0);

        // 5: back-to-back frames, strobe held high
        q_ready = 1'b0;
        send_frame(4'b1000, 1'b1, 0, 0, 0);
        check_word("b2b_first", qp, 4'b1000);
        send_frame(4'b0001, 1'b1, 0, 0, 1);
        check_bit("b2b_valid", q_valid, 1'b1);
        check_word("b2b_second", qp, 4'b0001);
        check_bit("b2b_ovr", ovr, 1'b0);
        tick();
        check_bit("b2b_fall", q_valid, 1'b0);

        // 6: long gaps between strobes
        send_frame(4'b1011, 1'b1, 5, 0, 0);
        check_word("gap_qp", qp, 4'b1011);
        tick();

        // Randomized frames, gaps, ready and overrun clears
        rand_mode = 1'b1;
        repeat (40) begin
            send_frame(W'($urandom), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 2)) strobe(1'b0, 1);
        end
        rand_mode = 1'b0;
        clr_ovr = 1'b0;
        q_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d words left expected 0", exp_q.size());
        end
        check_bit("final_valid", q_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
